// File: rtl/detonator_code_player_if.sv
// Detonator button interface bundle.
// Groups the start/abort/code request lines and the button pulse and status
// lines between a code player and whatever consumes its pulses.
//   master : the code player (receives go/abort/code, drives buttons/status)
//   slave  : the harness side (drives go/abort/code, observes buttons/status)
// Signals:
//   go, abort      request strobes
//   code[15:0]     8 x 2-bit symbols, symbol 0 in code[1:0]
//   button0..2     single-cycle one-hot pulses
//   busy/done/err  playback status
//   pos[2:0]       index of the most recently pulsed symbol
//   seg[6:0]       active-low 7-segment echo
interface detonator_code_player_if;
  logic        go;
  logic        abort;
  logic [15:0] code;
  logic        button0;
  logic        button1;
  logic        button2;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  pos;
  logic [6:0]  seg;

  modport master (
    input  go, abort, code,
    output button0, button1, button2, busy, done, err, pos, seg
  );

  modport slave (
    output go, abort, code,
    input  button0, button1, button2, busy, done, err, pos, seg
  );
endinterface

// File: rtl/detonator_code_player.sv
// detonator_code_player
// Plays an 8-symbol code as one-hot single-cycle pulses on button0/1/2,
// with GAP idle cycles between pulses (pulse spacing GAP+1 cycles).
// Codes containing symbol 3 are rejected with a one-cycle err pulse.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    detonator_code_player_if.master (go/abort/code in; buttons,
//          busy, done, err, pos, seg out)
// Optional build macro: CODE_PLAYER_SEG_EN enables the 7-segment echo of
// the last played symbol; without it seg is tied to 7'h7F (blank).
// All outputs are registered: the output registers are loaded from the
// next-state decode so a pulse appears in the same cycle as its state.
module detonator_code_player #(
  parameter int GAP     = 12_500_000,
  parameter int NUM_SYM = 8
) (
  input logic clk,
  input logic rst_n,
  detonator_code_player_if.master bus
);

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      idx_reg, idx_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [15:0]     code_reg, code_next;
  logic [2:0]      button_reg, button_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [2:0]      pos_reg, pos_next;
  logic [NUM_SYM-1:0] sym_bad;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym_chk
      assign sym_bad[gi] = &bus.code[2*gi +: 2];
    end
  endgenerate

  function automatic logic [2:0] onehot(input logic [1:0] s);
    onehot = {s == 2'd2, s == 2'd1, s == 2'd0};
  endfunction

  function automatic logic [1:0] sym_of(input logic [15:0] c, input logic [2:0] i);
    sym_of = c[{i, 1'b0} +: 2];
  endfunction

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    code_next   = code_reg;
    button_next = 3'b000;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    pos_next    = pos_reg;
    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        // abort has priority over go so a simultaneous pair starts nothing
        if (bus.go && !bus.abort) begin
          if (|sym_bad) begin
            err_next = 1'b1;
          end else begin
            code_next   = bus.code;
            idx_next    = 3'd0;
            pos_next    = 3'd0;
            busy_next   = 1'b1;
            button_next = onehot(bus.code[1:0]);
            state_next  = S_PRESS;
          end
        end
      end
      S_PRESS: begin
        if (bus.abort) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (idx_reg == 3'(NUM_SYM - 1)) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = S_DONE;
        end else begin
          busy_next  = 1'b1;
          cnt_next   = CW'(GAP - 1);
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (cnt_reg == '0) begin
          idx_next    = idx_reg + 3'd1;
          pos_next    = idx_reg + 3'd1;
          button_next = onehot(sym_of(code_reg, idx_reg + 3'd1));
          busy_next   = 1'b1;
          state_next  = S_PRESS;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DONE: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      idx_reg    <= 3'd0;
      cnt_reg    <= '0;
      code_reg   <= 16'h0000;
      button_reg <= 3'b000;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      pos_reg    <= 3'd0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      code_reg   <= code_next;
      button_reg <= button_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      pos_reg    <= pos_next;
    end
  end

  assign bus.button0 = button_reg[0];
  assign bus.button1 = button_reg[1];
  assign bus.button2 = button_reg[2];
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.pos     = pos_reg;

`ifdef CODE_PLAYER_SEG_EN
  logic [6:0] seg_reg, seg_next;

  // A pulse shows its digit (this also covers the blank of an accepted go,
  // since the first pulse lands in the same cycle); err shows a dash; an
  // abort of a running playback blanks the digit.
  always_comb begin
    seg_next = seg_reg;
    if (button_next[0]) begin
      seg_next = 7'h40;
    end else if (button_next[1]) begin
      seg_next = 7'h79;
    end else if (button_next[2]) begin
      seg_next = 7'h24;
    end else if (err_next) begin
      seg_next = 7'h3F;
    end else if (bus.abort && state_reg != S_IDLE) begin
      seg_next = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= 7'h7F;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign bus.seg = seg_reg;
`else
  assign bus.seg = 7'h7F;
`endif

endmodule

// File: tb/tb_detonator_code_player.sv
// Directed testbench for detonator_code_player (GAP=3).
// Drives go/abort/code through the interface and compares every cycle of
// each playback against expected values derived from the code under test.
module tb_detonator_code_player;
  localparam int GAP = 3;
  localparam int PER = GAP + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [6:0] seg_now = 7'h7F;

  always #5 clk = ~clk;

  detonator_code_player_if bus_if ();

  detonator_code_player #(.GAP(GAP), .NUM_SYM(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_onehot(input logic [1:0] s);
    case (s)
      2'd0:    exp_onehot = 3'b001;
      2'd1:    exp_onehot = 3'b010;
      2'd2:    exp_onehot = 3'b100;
      default: exp_onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] seg_exp(input logic [6:0] v);
`ifdef CODE_PLAYER_SEG_EN
    seg_exp = v;
`else
    seg_exp = 7'h7F;
`endif
  endfunction

  function automatic logic [6:0] digit(input logic [1:0] s);
    case (s)
      2'd0:    digit = 7'h40;
      2'd1:    digit = 7'h79;
      default: digit = 7'h24;
    endcase
  endfunction

  function automatic logic [2:0] buttons();
    buttons = {bus_if.button2, bus_if.button1, bus_if.button0};
  endfunction

  task automatic check_quiet(input string tag, input logic [2:0] exp_pos);
    check({tag, " btn"},  32'(buttons()), 32'd0);
    check({tag, " busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, " done"}, 32'(bus_if.done), 32'd0);
    check({tag, " err"},  32'(bus_if.err), 32'd0);
    check({tag, " pos"},  32'(bus_if.pos), 32'(exp_pos));
    check({tag, " seg"},  32'(bus_if.seg), 32'(seg_exp(seg_now)));
  endtask

  // go is raised for cycle 0; k counts cycles after it. abort_k/go2_k = 0 means unused.
  task automatic run_seq(input string name, input logic [15:0] c, input int abort_k,
                         input int go2_k, input logic [15:0] c2, input int ncyc);
    logic [2:0] exp_btn;
    logic [2:0] exp_pos;
    logic [6:0] exp_seg;
    logic exp_busy, exp_done, alive;
    int p, npulse, nerr_before;
    exp_pos = 3'd0;
    exp_seg = 7'h7F;
    npulse = 0;
    nerr_before = errors;
    bus_if.code  = c;
    bus_if.go    = 1'b1;
    bus_if.abort = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      bus_if.go    = (k == go2_k);
      bus_if.abort = (k == abort_k);
      if (k == go2_k) bus_if.code = c2;
      alive = (abort_k == 0) || (k <= abort_k);
      p = (k - 1) / PER;
      exp_btn = 3'b000;
      if (((k - 1) % PER == 0) && p < 8 && alive) begin
        exp_btn = exp_onehot(c[2*p +: 2]);
        exp_pos = 3'(p);
        exp_seg = digit(c[2*p +: 2]);
        npulse++;
      end
      if (abort_k != 0 && k > abort_k) exp_seg = 7'h7F;
      exp_busy = alive && (k <= 1 + 7 * PER);
      exp_done = (abort_k == 0) && (k == 2 + 7 * PER);
      check($sformatf("%s k%0d btn", name, k),  32'(buttons()), 32'(exp_btn));
      check($sformatf("%s k%0d busy", name, k), 32'(bus_if.busy), 32'(exp_busy));
      check($sformatf("%s k%0d done", name, k), 32'(bus_if.done), 32'(exp_done));
      check($sformatf("%s k%0d err", name, k),  32'(bus_if.err), 32'd0);
      check($sformatf("%s k%0d pos", name, k),  32'(bus_if.pos), 32'(exp_pos));
      check($sformatf("%s k%0d seg", name, k),  32'(bus_if.seg), 32'(seg_exp(exp_seg)));
    end
    bus_if.go = 1'b0;
    bus_if.abort = 1'b0;
    seg_now = exp_seg;
    $display("%s: code=%h pulses=%0d new_errors=%0d", name, c, npulse, errors - nerr_before);
  endtask

  initial begin
    bus_if.go = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.code = 16'h0000;

    // Reset state
    step();
    step();
    check_quiet("reset", 3'd0);
    rst_n = 1'b1;
    step();
    check_quiet("post_reset", 3'd0);
    $display("reset: outputs at reset values");

    // Full playback: b1,b2,b0,b1,b2,b0,b1,b2 at k=1,5,...,29, done at 30
    run_seq("play_9249", 16'h9249, 0, 0, 16'h9249, 34);

    // Illegal symbol 3 in position 3
    bus_if.code = 16'h00C0;
    bus_if.go = 1'b1;
    step();
    bus_if.go = 1'b0;
    seg_now = 7'h3F;
    check("illegal k1 err", 32'(bus_if.err), 32'd1);
    check("illegal k1 btn", 32'(buttons()), 32'd0);
    check("illegal k1 busy", 32'(bus_if.busy), 32'd0);
    check("illegal k1 seg", 32'(bus_if.seg), 32'(seg_exp(seg_now)));
    for (int k = 2; k <= 5; k++) begin
      step();
      check_quiet($sformatf("illegal k%0d", k), 3'd7);
    end
    $display("illegal_00C0: err pulse checked");

    // go and abort together in IDLE: nothing starts
    bus_if.code = 16'h9249;
    bus_if.go = 1'b1;
    bus_if.abort = 1'b1;
    step();
    bus_if.go = 1'b0;
    bus_if.abort = 1'b0;
    check_quiet("go_abort k1", 3'd7);
    for (int k = 2; k <= 4; k++) begin
      step();
      check_quiet($sformatf("go_abort k%0d", k), 3'd7);
    end
    $display("go_abort_idle: no start");

    // A following go alone starts normally
    run_seq("play_1221", 16'h1221, 0, 0, 16'h1221, 33);

    // Abort during the GAP after the second pulse
    run_seq("abort_0000", 16'h0000, 6, 0, 16'h0000, 34);

    // Second go plus code change mid-playback are ignored
    run_seq("rego_5555", 16'h5555, 0, 8, 16'hAAAA, 34);

    // Asynchronous reset mid-playback
    bus_if.code = 16'h5555;
    bus_if.go = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      bus_if.go = 1'b0;
    end
    check("pre_rst pos", 32'(bus_if.pos), 32'd2);
    check("pre_rst busy", 32'(bus_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    seg_now = 7'h7F;
    check_quiet("async_rst", 3'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_quiet($sformatf("in_rst c%0d", k), 3'd0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_quiet($sformatf("after_rst c%0d", k), 3'd0);
    end
    $display("reset_mid_play: outputs cleared, no pulses");

    run_seq("play_AAAA", 16'hAAAA, 0, 0, 16'hAAAA, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
